// File: rtl/l2_set_buf_flush.sv
`default_nettype none
// ============================================================================
// Module   : l2_set_buf_flush
// Brief    : Per-set L2 working buffer with a registered tag lookup and a
//            dirty-way write-back walker.
// Revision : 1.0
// ============================================================================
module l2_set_buf_flush #(
  parameter int WAYS          = 8,
  parameter int WAY_W         = $clog2(WAYS),
  parameter int TAG_W         = 20,
  parameter int LINE_W        = 128,
  parameter int STATE_W       = 3,
  parameter int HPROT_W       = 1,
  parameter int INVALID_STATE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [WAYS*LINE_W-1:0]    rd_data_line,
  input  logic [WAYS*TAG_W-1:0]     rd_data_tag,
  input  logic [WAYS*STATE_W-1:0]   rd_data_state,
  input  logic [WAYS*HPROT_W-1:0]   rd_data_hprot,
  input  logic [WAY_W-1:0]          rd_data_evict_way,
  input  logic [WAY_W-1:0]          wr_way,
  input  logic                      wr_en_line,
  input  logic                      wr_en_tag,
  input  logic                      wr_en_state,
  input  logic                      wr_en_hprot,
  input  logic [LINE_W-1:0]         wr_line,
  input  logic [TAG_W-1:0]          wr_tag,
  input  logic [STATE_W-1:0]        wr_state,
  input  logic [HPROT_W-1:0]        wr_hprot,
  input  logic                      incr_evict,
  input  logic                      lookup_req,
  input  logic [TAG_W-1:0]          lookup_tag,
  output logic                      lookup_done,
  output logic                      lookup_hit,
  output logic [WAY_W-1:0]          lookup_way,
  input  logic                      flush_start,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [WAY_W-1:0]          wb_way,
  output logic [LINE_W-1:0]         wb_line,
  output logic [TAG_W-1:0]          wb_tag,
  output logic                      flush_busy,
  output logic                      flush_done,
  output logic [WAYS*LINE_W-1:0]    lines_buf,
  output logic [WAYS*TAG_W-1:0]     tags_buf,
  output logic [WAYS*STATE_W-1:0]   states_buf,
  output logic [WAYS*HPROT_W-1:0]   hprots_buf,
  output logic [WAYS-1:0]           dirty_buf,
  output logic [WAY_W-1:0]          evict_way_buf
);

  localparam logic [STATE_W-1:0] c_invalid  = STATE_W'(INVALID_STATE);
  localparam logic [WAY_W-1:0]   c_last_way = WAY_W'(WAYS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_WB   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WAY_W-1:0] r_cursor;
  logic             w_upd_en;
  logic             w_wb_fire;
  logic             w_hit;
  logic [WAY_W-1:0] w_hit_way;
  logic             w_scan_found;
  logic [WAY_W-1:0] w_scan_way;

  // Buffer updates are frozen for the whole walk so the write-back sees a stable set.
  assign w_upd_en  = (r_state == S_IDLE);
  assign w_wb_fire = (r_state == S_WB) && wb_ready;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    logic [LINE_W-1:0]  r_line;
    logic [TAG_W-1:0]   r_tag;
    logic [STATE_W-1:0] r_st;
    logic [HPROT_W-1:0] r_hprot;
    logic               r_dirty;
    logic               w_wsel;
    logic               w_clr;

    assign w_wsel = w_upd_en && (wr_way == WAY_W'(gi));
    assign w_clr  = w_wb_fire && (wb_way == WAY_W'(gi));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_line  <= '0;
        r_tag   <= '0;
        r_st    <= '0;
        r_hprot <= '0;
        r_dirty <= 1'b0;
      end else if (load && w_upd_en) begin
        r_line  <= rd_data_line[gi*LINE_W +: LINE_W];
        r_tag   <= rd_data_tag[gi*TAG_W +: TAG_W];
        r_st    <= rd_data_state[gi*STATE_W +: STATE_W];
        r_hprot <= rd_data_hprot[gi*HPROT_W +: HPROT_W];
        r_dirty <= 1'b0;
      end else if (w_wsel) begin
        if (wr_en_line) begin
          r_line  <= wr_line;
          r_dirty <= 1'b1;
        end
        if (wr_en_tag)   r_tag   <= wr_tag;
        if (wr_en_state) r_st    <= wr_state;
        if (wr_en_hprot) r_hprot <= wr_hprot;
      end else if (w_clr) begin
        r_dirty <= 1'b0;
      end
    end

    assign lines_buf[gi*LINE_W +: LINE_W]    = r_line;
    assign tags_buf[gi*TAG_W +: TAG_W]       = r_tag;
    assign states_buf[gi*STATE_W +: STATE_W] = r_st;
    assign hprots_buf[gi*HPROT_W +: HPROT_W] = r_hprot;
    assign dirty_buf[gi]                     = r_dirty;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evict_way_buf <= '0;
    end else if (w_upd_en) begin
      if (load)            evict_way_buf <= rd_data_evict_way;
      else if (incr_evict) evict_way_buf <= evict_way_buf + 1'b1;
    end
  end

  // Descending scans so the lowest qualifying index is the last one assigned.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if ((states_buf[i*STATE_W +: STATE_W] != c_invalid) &&
          (tags_buf[i*TAG_W +: TAG_W] == lookup_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(i);
      end
    end
  end

  always_comb begin
    w_scan_found = 1'b0;
    w_scan_way   = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (dirty_buf[i] && (WAY_W'(i) >= r_cursor)) begin
        w_scan_found = 1'b1;
        w_scan_way   = WAY_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lookup_done <= 1'b0;
      lookup_hit  <= 1'b0;
      lookup_way  <= '0;
    end else begin
      lookup_done <= lookup_req;
      lookup_hit  <= lookup_req && w_hit;
      lookup_way  <= lookup_req ? w_hit_way : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    wb_valid    = 1'b0;
    flush_busy  = (r_state != S_IDLE);
    flush_done  = 1'b0;
    case (r_state)
      S_IDLE: if (flush_start) w_state_nxt = S_SCAN;
      S_SCAN: w_state_nxt = w_scan_found ? S_WB : S_DONE;
      S_WB: begin
        wb_valid = 1'b1;
        if (wb_ready) w_state_nxt = (wb_way == c_last_way) ? S_DONE : S_SCAN;
      end
      S_DONE: begin
        flush_done  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cursor <= '0;
      wb_way   <= '0;
      wb_line  <= '0;
      wb_tag   <= '0;
    end else begin
      if ((r_state == S_IDLE) && flush_start) r_cursor <= '0;
      if (w_wb_fire)                          r_cursor <= wb_way + 1'b1;
      if ((r_state == S_SCAN) && w_scan_found) begin
        wb_way  <= w_scan_way;
        wb_line <= lines_buf[w_scan_way*LINE_W +: LINE_W];
        wb_tag  <= tags_buf[w_scan_way*TAG_W +: TAG_W];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l2_set_buf_flush.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_set_buf_flush
// Brief    : Directed self-checking bench for l2_set_buf_flush.
// Revision : 1.0
// ============================================================================
module tb_l2_set_buf_flush;

  localparam int WAYS = 8, WAY_W = 3, TAG_W = 20, LINE_W = 128, STATE_W = 3, HPROT_W = 1;
  localparam logic [LINE_W-1:0] c_l2 = {4{32'h0202_BEEF}};
  localparam logic [LINE_W-1:0] c_l6 = {4{32'h0606_BEEF}};
  localparam logic [LINE_W-1:0] c_l7 = {4{32'h0707_BEEF}};

  logic clk = 1'b0, rst = 1'b0;
  logic load = 0, wr_en_line = 0, wr_en_tag = 0, wr_en_state = 0, wr_en_hprot = 0;
  logic incr_evict = 0, lookup_req = 0, flush_start = 0, wb_ready = 0;
  logic [WAYS*LINE_W-1:0]  rd_data_line = '0;
  logic [WAYS*TAG_W-1:0]   rd_data_tag = '0;
  logic [WAYS*STATE_W-1:0] rd_data_state = '0;
  logic [WAYS*HPROT_W-1:0] rd_data_hprot = '0;
  logic [WAY_W-1:0]        rd_data_evict_way = '0, wr_way = '0;
  logic [LINE_W-1:0]       wr_line = '0;
  logic [TAG_W-1:0]        wr_tag = '0, lookup_tag = '0;
  logic [STATE_W-1:0]      wr_state = '0;
  logic [HPROT_W-1:0]      wr_hprot = '0;

  logic                    lookup_done, lookup_hit, wb_valid, flush_busy, flush_done;
  logic [WAY_W-1:0]        lookup_way, wb_way, evict_way_buf;
  logic [LINE_W-1:0]       wb_line;
  logic [TAG_W-1:0]        wb_tag;
  logic [WAYS*LINE_W-1:0]  lines_buf;
  logic [WAYS*TAG_W-1:0]   tags_buf;
  logic [WAYS*STATE_W-1:0] states_buf;
  logic [WAYS*HPROT_W-1:0] hprots_buf;
  logic [WAYS-1:0]         dirty_buf;

  int checks = 0, errors = 0;

  l2_set_buf_flush dut (
    .clk(clk), .rst(rst), .load(load),
    .rd_data_line(rd_data_line), .rd_data_tag(rd_data_tag),
    .rd_data_state(rd_data_state), .rd_data_hprot(rd_data_hprot),
    .rd_data_evict_way(rd_data_evict_way), .wr_way(wr_way),
    .wr_en_line(wr_en_line), .wr_en_tag(wr_en_tag), .wr_en_state(wr_en_state),
    .wr_en_hprot(wr_en_hprot), .wr_line(wr_line), .wr_tag(wr_tag),
    .wr_state(wr_state), .wr_hprot(wr_hprot), .incr_evict(incr_evict),
    .lookup_req(lookup_req), .lookup_tag(lookup_tag), .lookup_done(lookup_done),
    .lookup_hit(lookup_hit), .lookup_way(lookup_way), .flush_start(flush_start),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_way(wb_way), .wb_line(wb_line),
    .wb_tag(wb_tag), .flush_busy(flush_busy), .flush_done(flush_done),
    .lines_buf(lines_buf), .tags_buf(tags_buf), .states_buf(states_buf),
    .hprots_buf(hprots_buf), .dirty_buf(dirty_buf), .evict_way_buf(evict_way_buf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [LINE_W-1:0] pat(input int i);
    return {4{32'hA5A5_0000 + 32'(i)}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if ((|{lookup_done, lookup_hit, lookup_way, wb_valid, wb_way, wb_line, wb_tag,
           flush_busy, flush_done, lines_buf, tags_buf, states_buf, hprots_buf,
           dirty_buf, evict_way_buf}) !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got nonzero busy=%b dirty=%h evict=%0d want all 0",
               flush_busy, dirty_buf, evict_way_buf);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_load();
    logic [WAYS*LINE_W-1:0] el;
    logic [WAYS*TAG_W-1:0]  et;
    logic [WAYS*STATE_W-1:0] es;
    logic [WAYS*HPROT_W-1:0] eh;
    for (int i = 0; i < WAYS; i++) begin
      el[i*LINE_W +: LINE_W]    = pat(i);
      et[i*TAG_W +: TAG_W]      = TAG_W'(32'h10 + i);
      es[i*STATE_W +: STATE_W]  = 3'd1;
      eh[i*HPROT_W +: HPROT_W]  = 1'(i);
    end
    rd_data_line = el; rd_data_tag = et; rd_data_state = es; rd_data_hprot = eh;
    rd_data_evict_way = 3'd5;
    load = 1; tick(); load = 0;
    checks++;
    if (lines_buf !== el || tags_buf !== et) begin
      errors++; $display("FAIL load_line_tag got tags %h want %h", tags_buf, et);
    end
    checks++;
    if (states_buf !== es || hprots_buf !== eh) begin
      errors++; $display("FAIL load_state_hprot got %h/%h want %h/%h", states_buf, hprots_buf, es, eh);
    end
    checks++;
    if (dirty_buf !== 8'h00 || evict_way_buf !== 3'd5) begin
      errors++; $display("FAIL load_dirty_evict got %h/%0d want 00/5", dirty_buf, evict_way_buf);
    end
  endtask

  task automatic test_evict();
    logic [WAY_W-1:0] exp_seq [4] = '{3'd6, 3'd7, 3'd0, 3'd1};
    incr_evict = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (evict_way_buf !== exp_seq[k]) begin
        errors++; $display("FAIL incr_evict_%0d got %0d want %0d", k, evict_way_buf, exp_seq[k]);
      end
    end
    rd_data_evict_way = 3'd3; load = 1;
    tick();
    load = 0; incr_evict = 0;
    checks++;
    if (evict_way_buf !== 3'd3) begin
      errors++; $display("FAIL load_over_incr got %0d want 3", evict_way_buf);
    end
  endtask

  task automatic test_lookup();
    lookup_req = 1; lookup_tag = 20'h13; tick(); lookup_req = 0;
    checks++;
    if ({lookup_done, lookup_hit, lookup_way} !== {1'b1, 1'b1, 3'd3}) begin
      errors++; $display("FAIL lookup_hit3 got %b%b%0d want 1 1 3", lookup_done, lookup_hit, lookup_way);
    end
    tick();
    checks++;
    if (lookup_done !== 1'b0) begin
      errors++; $display("FAIL lookup_done_pulse got %b want 0", lookup_done);
    end
    wr_way = 3'd3; wr_en_state = 1; wr_state = 3'd0; tick(); wr_en_state = 0;
    lookup_req = 1; tick(); lookup_req = 0;
    checks++;
    if ({lookup_done, lookup_hit, lookup_way} !== {1'b1, 1'b0, 3'd0}) begin
      errors++; $display("FAIL lookup_invalid got %b%b%0d want 1 0 0", lookup_done, lookup_hit, lookup_way);
    end
    wr_en_state = 1; wr_state = 3'd1; tick(); wr_en_state = 0;
    wr_way = 3'd6; wr_en_tag = 1; wr_tag = 20'h13; tick(); wr_en_tag = 0;
    lookup_req = 1; tick(); lookup_req = 0;
    checks++;
    if ({lookup_hit, lookup_way} !== {1'b1, 3'd3}) begin
      errors++; $display("FAIL lookup_lowest got %b%0d want 1 3", lookup_hit, lookup_way);
    end
    wr_en_tag = 1; wr_tag = 20'h16; tick(); wr_en_tag = 0;
    checks++;
    if (dirty_buf !== 8'h00 || tags_buf[6*TAG_W +: TAG_W] !== 20'h16) begin
      errors++; $display("FAIL field_write_no_dirty got %h/%h want 00/16", dirty_buf, tags_buf[6*TAG_W +: TAG_W]);
    end
  endtask

  task automatic test_flush_two_beats();
    wr_en_line = 1; wr_way = 3'd2; wr_line = c_l2; tick();
    wr_way = 3'd6; wr_line = c_l6; tick(); wr_en_line = 0;
    checks++;
    if (dirty_buf !== 8'h44) begin
      errors++; $display("FAIL wr_line_dirty got %h want 44", dirty_buf);
    end
    wb_ready = 0; flush_start = 1; tick(); flush_start = 0;
    checks++;
    if (flush_busy !== 1'b1 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL scan_state got busy=%b valid=%b want 1 0", flush_busy, wb_valid);
    end
    wr_en_line = 1; wr_way = 3'd0; wr_line = '1; incr_evict = 1; load = 1;
    lookup_req = 1; lookup_tag = 20'h12;
    for (int k = 0; k < 3; k++) begin
      tick();
      lookup_req = 0;
      checks++;
      if ({wb_valid, wb_way, wb_line, wb_tag} !== {1'b1, 3'd2, c_l2, 20'h12}) begin
        errors++; $display("FAIL beat0_hold_%0d got v=%b way=%0d tag=%h want 1 2 12", k, wb_valid, wb_way, wb_tag);
      end
      if (k == 0) begin
        checks++;
        if ({lookup_done, lookup_hit, lookup_way} !== {1'b1, 1'b1, 3'd2}) begin
          errors++; $display("FAIL lookup_in_flush got %b%b%0d want 1 1 2", lookup_done, lookup_hit, lookup_way);
        end
      end
    end
    wr_en_line = 0; incr_evict = 0; load = 0; wb_ready = 1;
    tick();
    checks++;
    if (wb_valid !== 1'b0 || dirty_buf !== 8'h40) begin
      errors++; $display("FAIL beat0_clear got v=%b dirty=%h want 0 40", wb_valid, dirty_buf);
    end
    tick();
    checks++;
    if ({wb_valid, wb_way, wb_line, wb_tag} !== {1'b1, 3'd6, c_l6, 20'h16}) begin
      errors++; $display("FAIL beat1 got v=%b way=%0d tag=%h want 1 6 16", wb_valid, wb_way, wb_tag);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b0 || flush_done !== 1'b0 || dirty_buf !== 8'h00) begin
      errors++; $display("FAIL beat1_clear got v=%b done=%b dirty=%h want 0 0 00", wb_valid, flush_done, dirty_buf);
    end
    tick();
    checks++;
    if (flush_done !== 1'b1) begin
      errors++; $display("FAIL flush_done_pulse got %b want 1", flush_done);
    end
    tick();
    checks++;
    if (flush_done !== 1'b0 || flush_busy !== 1'b0) begin
      errors++; $display("FAIL flush_idle got done=%b busy=%b want 0 0", flush_done, flush_busy);
    end
    checks++;
    if (lines_buf[0 +: LINE_W] !== pat(0) || evict_way_buf !== 3'd3 || dirty_buf !== 8'h00) begin
      errors++; $display("FAIL writes_dropped got evict=%0d dirty=%h want 3 00", evict_way_buf, dirty_buf);
    end
  endtask

  task automatic test_last_way();
    wr_en_line = 1; wr_way = 3'd7; wr_line = c_l7; tick(); wr_en_line = 0;
    wb_ready = 1; flush_start = 1; tick(); flush_start = 0;
    tick();
    checks++;
    if ({wb_valid, wb_way, wb_line} !== {1'b1, 3'd7, c_l7}) begin
      errors++; $display("FAIL last_way_beat got v=%b way=%0d want 1 7", wb_valid, wb_way);
    end
    tick();
    checks++;
    if (flush_done !== 1'b1 || wb_valid !== 1'b0 || dirty_buf !== 8'h00) begin
      errors++; $display("FAIL last_way_done got done=%b v=%b dirty=%h want 1 0 00", flush_done, wb_valid, dirty_buf);
    end
    tick();
  endtask

  task automatic test_no_dirty();
    flush_start = 1; tick();
    checks++;
    if (flush_busy !== 1'b1 || wb_valid !== 1'b0 || flush_done !== 1'b0) begin
      errors++; $display("FAIL nodirty_scan got busy=%b v=%b done=%b want 1 0 0", flush_busy, wb_valid, flush_done);
    end
    tick();
    flush_start = 0;
    checks++;
    if (flush_done !== 1'b1 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL nodirty_done got done=%b v=%b want 1 0", flush_done, wb_valid);
    end
    tick();
    tick();
    checks++;
    if (flush_busy !== 1'b0 || flush_done !== 1'b0) begin
      errors++; $display("FAIL busy_start_ignored got busy=%b done=%b want 0 0", flush_busy, flush_done);
    end
  endtask

  task automatic test_reset_mid_flush();
    wr_en_line = 1; wr_way = 3'd1; wr_line = c_l2; tick(); wr_en_line = 0;
    wb_ready = 0; flush_start = 1; tick(); flush_start = 0;
    tick();
    checks++;
    if (wb_valid !== 1'b1 || wb_way !== 3'd1) begin
      errors++; $display("FAIL pre_reset_beat got v=%b way=%0d want 1 1", wb_valid, wb_way);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ((|{lookup_done, lookup_hit, lookup_way, wb_valid, wb_way, wb_line, wb_tag,
           flush_busy, flush_done, lines_buf, tags_buf, states_buf, hprots_buf,
           dirty_buf, evict_way_buf}) !== 1'b0) begin
      errors++; $display("FAIL async_reset got v=%b busy=%b dirty=%h want all 0", wb_valid, flush_busy, dirty_buf);
    end
    tick();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (flush_busy !== 1'b0 || wb_valid !== 1'b0 || dirty_buf !== 8'h00) begin
      errors++; $display("FAIL post_reset_idle got busy=%b v=%b dirty=%h want 0 0 00", flush_busy, wb_valid, dirty_buf);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_evict();
    test_lookup();
    test_flush_two_beats();
    test_last_way();
    test_no_dirty();
    test_reset_mid_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
